// File: rtl/icache.sv
// Direct-mapped instruction cache with word-serial refill from memory.
// Define ICACHE_PERF_EN to add hit_cnt/miss_cnt counters.
module icache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 1,
  parameter int CACHE_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  IF2IC_en,
  input  logic [ADDR_WIDTH-1:0] IF2IC_addr,
  output logic                  IC2IF_en,
  output logic [31:0]           IC2IF_data,
  input  logic                  ROB2IC_flush,
  output logic                  IC2MC_en,
  output logic [ADDR_WIDTH-1:0] IC2MC_addr,
  input  logic                  MC2IC_en,
  input  logic [31:0]           MC2IC_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
  localparam int BLOCK_NUM  = 1 << CACHE_WIDTH;
  localparam int LINE_LSB   = BLOCK_WIDTH + 2;
  localparam int TAG_LSB    = CACHE_WIDTH + BLOCK_WIDTH + 2;
  localparam int TAG_W      = ADDR_WIDTH - TAG_LSB;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MISS = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [BLOCK_WIDTH-1:0] LAST = {BLOCK_WIDTH{1'b1}};

  logic [1:0]             state_q, state_d;
  logic [BLOCK_WIDTH-1:0] cnt_q, cnt_d;
  logic [BLOCK_WIDTH-1:0] off_q, off_d;
  logic [CACHE_WIDTH-1:0] idx_q, idx_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic                   drop_q, drop_d;
  logic [BLOCK_NUM-1:0]   valid_q, valid_d;
  logic                   if_en_q, if_en_d;
  logic [31:0]            if_data_q, if_data_d;

  logic [TAG_W-1:0] tag_mem [BLOCK_NUM];
  logic [31:0]      data_mem [BLOCK_NUM*BLOCK_SIZE];
  logic             data_we;
  logic             tag_we;

  logic [BLOCK_WIDTH-1:0] req_off;
  logic [CACHE_WIDTH-1:0] req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic                   req_hit;
  logic                   last_word;
  logic                   drop_now;
  logic                   unused_addr;

  assign req_off     = IF2IC_addr[LINE_LSB-1:2];
  assign req_idx     = IF2IC_addr[TAG_LSB-1:LINE_LSB];
  assign req_tag     = IF2IC_addr[ADDR_WIDTH-1:TAG_LSB];
  assign req_hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last_word   = (cnt_q == LAST);
  assign drop_now    = drop_q | ROB2IC_flush;
  assign unused_addr = ^IF2IC_addr[1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    drop_d    = drop_q;
    valid_d   = valid_q;
    if_en_d   = if_en_q;
    if_data_d = if_data_q;
    data_we   = 1'b0;
    tag_we    = 1'b0;
    if (rdy_in) begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          if (IF2IC_en && !ROB2IC_flush) begin
            if (req_hit) begin
              if_en_d   = 1'b1;
              if_data_d = data_mem[{req_idx, req_off}];
              state_d   = S_RESP;
            end else begin
              tag_d   = req_tag;
              idx_d   = req_idx;
              off_d   = req_off;
              cnt_d   = '0;
              drop_d  = 1'b0;
              state_d = S_MISS;
            end
          end
        end
        (state_q == S_MISS): begin
          if (ROB2IC_flush) drop_d = 1'b1;
          if (MC2IC_en) begin
            data_we = 1'b1;
            cnt_d   = cnt_q + BLOCK_WIDTH'(1);
            if (last_word) begin
              tag_we         = 1'b1;
              valid_d[idx_q] = 1'b1;
              drop_d         = 1'b0;
              if (drop_now) begin
                state_d = S_IDLE;
              end else begin
                // last word is not in the array yet: forward it
                if_data_d = (off_q == LAST) ? MC2IC_data
                                            : data_mem[{idx_q, off_q}];
                if_en_d   = 1'b1;
                state_d   = S_RESP;
              end
            end
          end
        end
        (state_q == S_RESP): begin
          if_en_d = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      off_q     <= '0;
      idx_q     <= '0;
      tag_q     <= '0;
      drop_q    <= 1'b0;
      valid_q   <= '0;
      if_en_q   <= 1'b0;
      if_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      idx_q     <= idx_d;
      tag_q     <= tag_d;
      drop_q    <= drop_d;
      valid_q   <= valid_d;
      if_en_q   <= if_en_d;
      if_data_q <= if_data_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (data_we) data_mem[{idx_q, cnt_q}] <= MC2IC_data;
    if (tag_we) tag_mem[idx_q] <= tag_q;
  end

  assign IC2IF_en   = if_en_q;
  assign IC2IF_data = if_data_q;
  assign IC2MC_en   = (state_q == S_MISS);
  assign IC2MC_addr = IC2MC_en ? {tag_q, idx_q, cnt_q, 2'b00} : '0;

`ifdef ICACHE_PERF_EN
  logic        acc_hit;
  logic        acc_miss;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  assign acc_hit  = rdy_in && (state_q == S_IDLE) && IF2IC_en &&
                    !ROB2IC_flush && req_hit;
  assign acc_miss = rdy_in && (state_q == S_IDLE) && IF2IC_en &&
                    !ROB2IC_flush && !req_hit;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + 32'(acc_hit);
    miss_cnt_d = miss_cnt_q + 32'(acc_miss);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache against a line-level cache model
// and a fixed-function memory image.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        IF2IC_en;
  logic [31:0] IF2IC_addr;
  logic        IC2IF_en;
  logic [31:0] IC2IF_data;
  logic        ROB2IC_flush;
  logic        IC2MC_en;
  logic [31:0] IC2MC_addr;
  logic        MC2IC_en;
  logic [31:0] MC2IC_data;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rdy_in      (rdy_in),
    .IF2IC_en    (IF2IC_en),
    .IF2IC_addr  (IF2IC_addr),
    .IC2IF_en    (IC2IF_en),
    .IC2IF_data  (IC2IF_data),
    .ROB2IC_flush(ROB2IC_flush),
    .IC2MC_en    (IC2MC_en),
    .IC2MC_addr  (IC2MC_addr),
    .MC2IC_en    (MC2IC_en),
    .MC2IC_data  (MC2IC_data)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_mc[$];
  logic [31:0] exp_if[$];
  logic [31:0] seen_mc[$];
  logic [31:0] last_if = '0;

  bit          mv [256];
  logic [20:0] mt [256];
  int          m_hits = 0;
  int          m_misses = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h1234_5678;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic expect_req(input logic [31:0] a, input bit fl,
                            output bit hit);
    int idx;
    logic [20:0] tg;
    idx = int'(a[10:3]);
    tg  = a[31:11];
    hit = mv[idx] && (mt[idx] == tg);
    if (hit) begin
      m_hits++;
    end else begin
      for (int w = 0; w < 2; w++)
        exp_mc.push_back({a[31:3], 3'b000} + 32'(4 * w));
      mv[idx] = 1'b1;
      mt[idx] = tg;
      m_misses++;
    end
    if (hit || !fl) exp_if.push_back(mem_word(a));
  endtask

  task automatic fetch(input logic [31:0] a, input bit fl);
    bit hit;
    int n;
    int s0;
    expect_req(a, fl, hit);
    s0 = seen_mc.size();
    @(negedge clk_in);
    IF2IC_en   = 1'b1;
    IF2IC_addr = a;
    @(negedge clk_in);
    if (hit) begin
      chk("hit_lat", 32'(IC2IF_en), 32'd1);
      IF2IC_en = 1'b0;
    end else if (!fl) begin
      n = 0;
      while (!IC2IF_en && n < 200) begin
        @(negedge clk_in);
        n++;
      end
      chk("fill_done", 32'(IC2IF_en), 32'd1);
      IF2IC_en = 1'b0;
    end else begin
      n = 0;
      while (seen_mc.size() == s0 && n < 200) begin
        @(negedge clk_in);
        n++;
      end
      chk("flush_win", 32'(IC2MC_en), 32'd1);
      ROB2IC_flush = 1'b1;
      IF2IC_en     = 1'b0;
      @(negedge clk_in);
      ROB2IC_flush = 1'b0;
      n = 0;
      while (IC2MC_en && n < 200) begin
        @(negedge clk_in);
        n++;
      end
      chk("drop_end", 32'(IC2MC_en), 32'd0);
      @(negedge clk_in);
    end
    @(negedge clk_in);
    chk("if_low", 32'(IC2IF_en), 32'd0);
  endtask

  // Memory: answers each word request after 0-2 cycles, holding the
  // pulse until a cycle where rdy_in lets the cache take it.
  initial begin
    MC2IC_en   = 1'b0;
    MC2IC_data = '0;
    forever begin
      @(negedge clk_in);
      MC2IC_en = 1'b0;
      if (IC2MC_en && rst_n_in) begin
        repeat ($urandom_range(0, 2)) @(negedge clk_in);
        if (!IC2MC_en) continue;
        MC2IC_en   = 1'b1;
        MC2IC_data = mem_word(IC2MC_addr);
        forever begin
          @(posedge clk_in);
          if (rdy_in || !rst_n_in) break;
        end
      end
    end
  end

  // Compare process: sampled just before each rising edge.
  initial begin
    forever begin
      @(negedge clk_in);
      #4;
      if (rst_n_in) begin
        chk("exclusive", 32'(IC2IF_en & IC2MC_en), 32'd0);
        if (IC2MC_en) begin
          chk("mc_pending", 32'(exp_mc.size() != 0), 32'd1);
          if (exp_mc.size() != 0) begin
            chk("mc_addr", IC2MC_addr, exp_mc[0]);
            if (MC2IC_en && rdy_in) begin
              seen_mc.push_back(IC2MC_addr);
              void'(exp_mc.pop_front());
            end
          end
        end
        if (IC2IF_en && rdy_in) begin
          chk("if_pending", 32'(exp_if.size() != 0), 32'd1);
          if (exp_if.size() != 0) begin
            chk("if_data", IC2IF_data, exp_if[0]);
            void'(exp_if.pop_front());
          end
          last_if = IC2IF_data;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    rst_n_in     = 1'b0;
    rdy_in       = 1'b1;
    IF2IC_en     = 1'b0;
    IF2IC_addr   = '0;
    ROB2IC_flush = 1'b0;
    #12;
    chk("rst_if_en", 32'(IC2IF_en), 32'd0);
    chk("rst_if_data", IC2IF_data, 32'd0);
    chk("rst_mc_en", 32'(IC2MC_en), 32'd0);
    chk("rst_mc_addr", IC2MC_addr, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    fetch(32'h0, 1'b0);
    chk("d1_nmc", 32'(seen_mc.size()), 32'd2);
    chk("d1_mc0", seen_mc[0], 32'h0);
    chk("d1_mc1", seen_mc[1], 32'h4);
    chk("d1_data", last_if, 32'h1234_5678);
`ifdef ICACHE_PERF_EN
    chk("d1_miss_cnt", miss_cnt, 32'd1);
`endif

    fetch(32'h4, 1'b0);
    chk("d2_nmc", 32'(seen_mc.size()), 32'd2);
    chk("d2_data", last_if, 32'h8B12_3D5C);

    fetch(32'h800, 1'b0);
    chk("d3_mc0", seen_mc[2], 32'h800);
    chk("d3_mc1", seen_mc[3], 32'h804);
    fetch(32'h0, 1'b0);
    chk("d3_remiss", 32'(seen_mc.size()), 32'd6);

    fetch(32'h44, 1'b1);
    n = seen_mc.size();
    fetch(32'h44, 1'b0);
    chk("d4_hit", 32'(seen_mc.size()), 32'(n));
    chk("d4_data", last_if, mem_word(32'h44));

    for (int i = 0; i < 150; i++) begin
      a = (32'($urandom_range(0, 3)) << 11) |
          (32'($urandom_range(0, 7)) << 3) |
          (32'($urandom_range(0, 1)) << 2);
      fetch(a, $urandom_range(0, 5) == 0);
    end

    // asynchronous reset in the middle of a refill
    begin
      bit h;
      expect_req(32'h7F8, 1'b0, h);
      @(negedge clk_in);
      IF2IC_en   = 1'b1;
      IF2IC_addr = 32'h7F8;
      @(negedge clk_in);
      chk("r_miss", 32'(IC2MC_en), 32'd1);
      #2;
      rst_n_in = 1'b0;
      #1;
      chk("r_mc_en", 32'(IC2MC_en), 32'd0);
      chk("r_mc_addr", IC2MC_addr, 32'd0);
      exp_mc.delete();
      exp_if.delete();
      foreach (mv[i]) mv[i] = 1'b0;
      m_hits   = 0;
      m_misses = 0;
      IF2IC_en = 1'b0;
      @(negedge clk_in);
      rst_n_in = 1'b1;
    end
    fetch(32'h7F8, 1'b0);
    chk("r_refetch", seen_mc[seen_mc.size()-2], 32'h7F8);

    // rdy_in low while a memory word is presented
    begin
      bit h;
      expect_req(32'h3F0, 1'b0, h);
      n = seen_mc.size();
      @(negedge clk_in);
      IF2IC_en   = 1'b1;
      IF2IC_addr = 32'h3F0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk_in);
        #1;
        if (MC2IC_en) break;
      end
      rdy_in = 1'b0;
      repeat (3) begin
        @(negedge clk_in);
        chk("rdy_mc_en", 32'(IC2MC_en), 32'd1);
        chk("rdy_mc_addr", IC2MC_addr, 32'h3F0);
        chk("rdy_nmc", 32'(seen_mc.size()), 32'(n));
      end
      rdy_in = 1'b1;
      for (int k = 0; k < 200; k++) begin
        if (IC2IF_en) break;
        @(negedge clk_in);
      end
      chk("rdy_fill", 32'(IC2IF_en), 32'd1);
      IF2IC_en = 1'b0;
      @(negedge clk_in);
      chk("rdy_mc0", seen_mc[n], 32'h3F0);
      chk("rdy_mc1", seen_mc[n+1], 32'h3F4);
      chk("rdy_data", last_if, mem_word(32'h3F0));
    end

    repeat (3) @(negedge clk_in);
    chk("mc_drained", 32'(exp_mc.size()), 32'd0);
    chk("if_drained", 32'(exp_if.size()), 32'd0);
`ifdef ICACHE_PERF_EN
    chk("hit_cnt", hit_cnt, 32'(m_hits));
    chk("miss_cnt", miss_cnt, 32'(m_misses));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all addresses.
REQ-002 Parameter BLOCK_WIDTH, default 1, log2 of 32-bit words per line; BLOCK_SIZE = 1 << BLOCK_WIDTH.
REQ-003 Parameter CACHE_WIDTH, default 8, log2 of line count; BLOCK_NUM = 1 << CACHE_WIDTH.
REQ-004 clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n_in  input  1  reset, asynchronous and active-low.
REQ-006 rdy_in  input  1  global ready; low freezes all state and outputs.
REQ-007 IF2IC_en  input  1  fetch request, held high until IC2IF_en is seen.
REQ-008 IF2IC_addr  input  ADDR_WIDTH  fetch byte address, word-aligned, stable while IF2IC_en is high.
REQ-009 IC2IF_en  output  1  registered one-cycle pulse: IC2IF_data is valid.
REQ-010 IC2IF_data  output  32  instruction word.
REQ-011 ROB2IC_flush  input  1  misprediction flush, one-cycle pulse.
REQ-012 IC2MC_en  output  1  memory word-read request, held until MC2IC_en.
REQ-013 IC2MC_addr  output  ADDR_WIDTH  memory word address, low 2 bits zero.
REQ-014 MC2IC_en  input  1  one-cycle pulse: MC2IC_data is valid.
REQ-015 MC2IC_data  input  32  word returned by memory.

Function
REQ-016 Direct-mapped: offset = addr[BLOCK_WIDTH+1:2], index = addr[CACHE_WIDTH+BLOCK_WIDTH+1:BLOCK_WIDTH+2], tag = the remaining upper bits; each line holds a valid bit, a tag and BLOCK_SIZE words.
REQ-017 States: IDLE, MISS, RESP.
REQ-018 IDLE, IF2IC_en=1, ROB2IC_flush=0, hit: IC2IF_data <= line word[offset], IC2IF_en <= 1, go to RESP; latency 1 cycle.
REQ-019 IDLE, IF2IC_en=1, ROB2IC_flush=0, miss: latch tag/index/offset, clear word counter, go to MISS.
REQ-020 IDLE with ROB2IC_flush=1 does not accept a request that cycle.
REQ-021 RESP lasts exactly one cycle with IC2IF_en=1, ignores IF2IC_en, then goes to IDLE; back-to-back hits give one word every 2 cycles.
REQ-022 MISS: IC2MC_en=1, IC2MC_addr = {tag, index, counter, 2'b00}; on MC2IC_en, write MC2IC_data into line word[counter] and increment counter.
REQ-023 Refill order is word 0 up to word BLOCK_SIZE-1; the next word's request is issued the cycle after MC2IC_en.
REQ-024 On the last word's MC2IC_en: set valid, write tag, drop IC2MC_en, load IC2IF_data with the latched offset word (bypass if it is the last word), IC2IF_en <= 1, go to RESP.
REQ-025 ROB2IC_flush during MISS sets a drop flag; the refill still completes and validates the line; then go to IDLE with no IC2IF_en pulse; the flag clears.
REQ-026 ROB2IC_flush during RESP does not retract the pulse; the fetcher discards it.
REQ-027 With rdy_in=0, ignore MC2IC_en and IF2IC_en; hold all registers and outputs.
REQ-028 IC2IF_en and IC2MC_en are never high in the same cycle.

Reset
REQ-029 rst_n_in low asynchronously clears all valid bits, clears the drop flag and counter, and sets state IDLE.
REQ-030 Reset sets IC2IF_en=0, IC2IF_data=0, IC2MC_en=0 and IC2MC_addr=0; an in-flight refill is abandoned and its line stays invalid.
REQ-031 Data and tag arrays are not reset.

Configuration
REQ-032 Macro ICACHE_PERF_EN defined: adds outputs hit_cnt and miss_cnt (32 bits each, reset 0, wrap at 2^32).
REQ-033 hit_cnt increments on each accepted hit; miss_cnt increments on each entry to MISS.
REQ-034 Macro ICACHE_PERF_EN absent: the ports and counters do not exist; all other behaviour is identical.

Verification
REQ-035 Reset, then request 0x0000_0000 -> IC2MC_addr 0x0 then 0x4; after the second MC2IC_en, IC2IF_en pulses with the word for 0x0; miss_cnt=1.
REQ-036 Request 0x0000_0004 right after REQ-035 -> hit, no IC2MC_en, IC2IF_en exactly 1 cycle after acceptance, data = the second refilled word.
REQ-037 Request 0x0000_0800, same index 0 with a different tag -> refill from 0x800 and 0x804, line 0 replaced; a following 0x0 request misses again.
REQ-038 ROB2IC_flush pulse between the two MC2IC_en of a refill -> refill completes, no IC2IF_en pulse; the same address requested next -> hit.
REQ-039 rst_n_in driven low mid-refill, asynchronously to the clock -> IC2MC_en drops immediately; after release, the same address misses.
REQ-040 rdy_in=0 for 3 cycles while the MC2IC_en pulse is presented -> no state change; the data is accepted on a later MC2IC_en after rdy_in returns high.
